odel_block: RTL
===============

# odel_block

Transmit-side counterpart of the PHY input-capture path. It accepts one 8-UI word per DQ line per `clk_div` cycle from the memory controller and applies a per-line coarse output delay of 0–15 UI. The delayed words are buffered in a 2-entry queue and written into the byte-group TX FIFOs only when every line's FIFO has space. The block sits between the memory controller write-data path and the PHY TX FIFOs and runs entirely in the system clock domain.

## Interface
- `LINES`, default 16: number of 8-bit DQ lines (e.g. DQ0–DQ15).
- `clk_div`, input, 1: system clock; the only clock.
- `rst_div`, input, 1: reset, synchronous and active-high.
- `param_io_out_del`, input, `LINES*4`: per-line output delay in UI (0–15); quasi-static.
- `tx_en`, input, 1: transmit enable.
- `phy_din[LINES-1:0]`, input, 8 each: controller write data; bit 0 is the earliest UI.
- `din_valid`, input, 1: `phy_din` holds a beat.
- `din_ready`, output, 1: the block can accept a beat this cycle.
- `tx_fifo_full`, input, `LINES`: per-line TX FIFO full flags.
- `tx_d[LINES-1:0]`, output, 8 each: TX FIFO write data; bit 7 is the earliest UI (PHY TX FIFO order).
- `tx_fifo_wren`, output, 1: common write enable for all lines.

## Operation
- Accept: `acc = din_valid && din_ready`.
- `din_ready = !rst_div && tx_en && (cnt != 2)`, where `cnt` is the queue occupancy.
- Per-line history registers `w1` and `w2` advance only on `acc`: `w2 <= w1`, `w1 <= phy_din[l]`. With no accept, the history is frozen.
- Delay selection is combinational on the accept cycle:
  - `H = {phy_din[l], w1, w2}` (24 bits, `w2` in `[7:0]`).
  - `sel[l] = H[(16-d[l])+:8]`, where `d[l]` is the registered `param_io_out_del[l*4+:4]`.
  - `d = 0` passes the current word; `d = 8` passes the previous beat.
- The delay parameter is registered once per cycle. A change takes effect on the next accept. The beats that straddle a change carry mixed data; this is allowed and not flagged.
- The selected word, bit-reversed per line, is pushed into the queue on `acc`.
- Pop: `pop = (cnt != 0) && &(~tx_fifo_full)`.
  - `tx_fifo_wren = pop && tx_en`.
  - `tx_d` = queue head, which is registered.
- Queue occupancy:
  - Push and pop in the same cycle: `cnt` unchanged.
  - Push only: `cnt + 1`.
  - Pop only: `cnt - 1`.
  - Push at `cnt = 2` cannot occur because `din_ready = 0`.
- Draining the delayed tail: the controller sends `ceil(max d / 8)` idle beats. The block does not self-flush.
- `tx_en` low:
  - `din_ready = 0` and `tx_fifo_wren = 0`.
  - History clears to 0 and the queue empties (`cnt = 0`) on the next edge.
  - Re-enable starts from zero history.

## Timing
- Reset values: `din_ready = 0`, `tx_fifo_wren = 0`, `tx_d = 0`, `cnt = 0`, history = 0, registered delays = 0.
- First accept is possible the cycle after `rst_div` deasserts.
- Latency: an accept at edge n gives `tx_fifo_wren` in cycle n+1 with the corresponding `tx_d`, provided no FIFO is full.
- Full handling:
  - Any `tx_fifo_full[l]` stalls all lines together.
  - At most two beats are absorbed before `din_ready` drops.
  - `din_ready` rises in the cycle after a pop frees an entry.
- Reset mid-operation discards queue and history; no write is issued in the reset cycle.
- Throughput: one beat per cycle while the FIFOs are not full.

## Structure
- `aimc_lib` gains:
  - `ODEL_DEL_W = 4`
  - `ODEL_HIST = 2` (history words)
  - `ODEL_QDEPTH = 2`
  - typedef `odel_word_t` (`logic [7:0]`)
- One sub-module, `odel_queue`: a 2-entry, `LINES*8`-wide FIFO with push, pop, `cnt`, head output and clear.
- Per-line history and selection are generated in a `for` loop in `odel_block`.

## Test plan
- Zero delay: all `d = 0`, beats `0x01, 0x02, 0x03` on line 0 with FIFOs never full -> `tx_d[0] = 0x80, 0x40, 0xC0`, each one cycle after its accept.
- Full-word delay: `d[3] = 8`, beats `0xAA, 0x55, 0x00` -> line 3 writes `0x00, 0x55, 0xAA` in bit-reversed form (`0x00, 0xAA, 0x55`).
- Sub-word delay: `d[0] = 4`, beats `0xF0, 0x0F` -> pre-reversal selections `0x00`, then `0xFF`.
- Backpressure: hold `tx_fifo_full[5] = 1` for 5 cycles during continuous valid -> exactly 2 beats accepted, `din_ready = 0`, no write. On release, queued beats are written in order and `din_ready` rises the cycle after the first pop.
- `tx_en` drop with `cnt = 2` -> no writes; `cnt = 0` and history = 0 next cycle. Re-enable with `d = 8` -> the first output is `0x00`.
- `rst_div` asserted mid-stream -> all outputs return to their reset values in the next cycle, and no stale beat is written after reset releases.

Source files
------------

// File: rtl/odel_block_pkg.sv
// Shared constants, word type and helpers for the transmit-side output delay path.
package aimc_lib;

    localparam int ODEL_DEL_W  = 4;
    localparam int ODEL_HIST   = 2;
    localparam int ODEL_QDEPTH = 2;

    typedef logic [7:0] odel_word_t;

    // Controller order has bit 0 earliest; the PHY TX FIFO wants bit 7 earliest.
    function automatic odel_word_t odel_bitrev(input odel_word_t w);
        odel_word_t r;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = w[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/odel_queue.sv
// Two-entry FIFO between the delay selection and the TX FIFO write port.
module odel_queue #(
    parameter int WIDTH = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       cnt_o
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_ok;

    assign pop_ok = pop_i && (cnt_q != 2'd0);

    // e0 is always the head, so a pop shifts e1 down.
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (clr_i) begin
            cnt_d = 2'd0;
            e0_d  = '0;
            e1_d  = '0;
        end else if (push_i && pop_ok) begin
            if (cnt_q == 2'd2) begin
                e0_d = e1_q;
                e1_d = din_i;
            end else begin
                e0_d = din_i;
            end
        end else if (push_i) begin
            if (cnt_q == 2'd0) begin
                e0_d = din_i;
            end else begin
                e1_d = din_i;
            end
            cnt_d = cnt_q + 2'd1;
        end else if (pop_ok) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign head_o = e0_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/odel_block.sv
// Per-line coarse output delay (0-15 UI) feeding the PHY TX FIFOs through a 2-entry queue.
module odel_block
    import aimc_lib::*;
#(
    parameter int LINES = 16
) (
    input  logic                        clk_div,
    input  logic                        rst_div,
    input  logic [LINES*ODEL_DEL_W-1:0] param_io_out_del,
    input  logic                        tx_en,
    input  logic [LINES-1:0][7:0]       phy_din,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic [LINES-1:0]            tx_fifo_full,
    output logic [LINES-1:0][7:0]       tx_d,
    output logic                        tx_fifo_wren
);

    logic [LINES*ODEL_DEL_W-1:0] del_q;
    logic [LINES-1:0][7:0]       sel_word;
    logic [LINES*8-1:0]          head;
    logic [1:0]                  cnt;
    logic                        acc;
    logic                        pop;

    assign din_ready    = !rst_div && tx_en && (cnt != 2'(ODEL_QDEPTH));
    assign acc          = din_valid && din_ready;
    assign pop          = !rst_div && tx_en && (cnt != 2'd0) && (&(~tx_fifo_full));
    assign tx_fifo_wren = pop;

    always_ff @(posedge clk_div) begin
        if (rst_div) begin
            del_q <= '0;
        end else begin
            del_q <= param_io_out_del;
        end
    end

    for (genvar l = 0; l < LINES; l++) begin : g_line
        odel_word_t  w1_q, w1_d;
        odel_word_t  w2_q, w2_d;
        logic [23:0] hist;
        logic [4:0]  idx;

        // History only moves on an accepted beat; disabling wipes it.
        always_comb begin
            w1_d = w1_q;
            w2_d = w2_q;
            if (!tx_en) begin
                w1_d = '0;
                w2_d = '0;
            end else if (acc) begin
                w2_d = w1_q;
                w1_d = phy_din[l];
            end
        end

        always_ff @(posedge clk_div) begin
            if (rst_div) begin
                w1_q <= '0;
                w2_q <= '0;
            end else begin
                w1_q <= w1_d;
                w2_q <= w2_d;
            end
        end

        assign hist        = {phy_din[l], w1_q, w2_q};
        assign idx         = 5'd16 - {1'b0, del_q[l*ODEL_DEL_W +: ODEL_DEL_W]};
        assign sel_word[l] = odel_bitrev(hist[idx +: 8]);
    end

    odel_queue #(
        .WIDTH(LINES*8)
    ) u_queue (
        .clk_i (clk_div),
        .rst_i (rst_div),
        .clr_i (!tx_en),
        .push_i(acc),
        .pop_i (pop),
        .din_i (sel_word),
        .head_o(head),
        .cnt_o (cnt)
    );

    assign tx_d = head;

endmodule
